// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared size codes, bus width and FSM encoding for mem_access_unit
package mem_access_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam int SZ_UNSIGNED = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering: store enables/replication, load extraction/extension, alignment check
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]        size,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] bus_word,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] lane_data,
    output logic [DATA_W-1:0] load_data,
    output logic              misalign
);

    logic        sign_ext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be        = 4'b1111;
        lane_data = store_data;
        load_data = bus_word;
        misalign  = 1'b0;
        sign_ext  = ~size[SZ_UNSIGNED];
        byte_sel  = bus_word[7:0];
        case (offset)
            2'd1:    byte_sel = bus_word[15:8];
            2'd2:    byte_sel = bus_word[23:16];
            2'd3:    byte_sel = bus_word[31:24];
            default: byte_sel = bus_word[7:0];
        endcase
        half_sel = offset[1] ? bus_word[31:16] : bus_word[15:0];

        // Reserved code 2'b11 and unsigned-word both fall through to word handling.
        case (size[1:0])
            SZ_B: begin
                be        = 4'b0001 << offset;
                lane_data = {4{store_data[7:0]}};
                load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                misalign  = offset[0];
                be        = 4'b0011 << offset;
                lane_data = {2{store_data[15:0]}};
                load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            end
            default: begin
                misalign  = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store responder on an ack-handshaked bus; optional MEM_ACCESS_TIMEOUT_EN
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] load_data,
    output logic              misalign,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_t            state;
    state_t            next_state;
    logic [1:0]        offset_q;
    logic [2:0]        size_q;
    logic              misalign_q;
    logic              timeout_hit;

    logic [2:0]        lane_size;
    logic [1:0]        lane_offset;
    logic [3:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_load;
    logic              lane_misalign;

    // One aligner serves both directions: request fields in IDLE, captured fields in REQ.
    assign lane_size   = (state == ST_IDLE) ? req_size : size_q;
    assign lane_offset = (state == ST_IDLE) ? req_addr[1:0] : offset_q;

    mem_lane_align u_lane (
        .size       (lane_size),
        .offset     (lane_offset),
        .store_data (req_wdata),
        .bus_word   (bus_rdata),
        .be         (lane_be),
        .lane_data  (lane_wdata),
        .load_data  (lane_load),
        .misalign   (lane_misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        bus_req    = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    next_state = lane_misalign ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                if (bus_ack || timeout_hit) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= 4'b0000;
            bus_wdata  <= '0;
            offset_q   <= 2'b00;
            size_q     <= 3'b000;
            misalign_q <= 1'b0;
            load_data  <= '0;
        end else begin
            // Result flags live for exactly the DONE cycle.
            misalign_q <= 1'b0;
            load_data  <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (lane_misalign) begin
                            misalign_q <= 1'b1;
                        end else begin
                            bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            bus_we    <= req_we;
                            bus_be    <= lane_be;
                            bus_wdata <= lane_wdata;
                            offset_q  <= req_addr[1:0];
                            size_q    <= req_size;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_ack && !bus_we) begin
                        load_data <= lane_load;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign misalign = misalign_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;
    logic             bus_err_q;

    // Counts unacknowledged REQ cycles; an ack on the final cycle still completes normally.
    assign timeout_hit = (state == ST_REQ) && !bus_ack && (to_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout_hit;
            if (state == ST_IDLE) begin
                to_cnt <= '0;
            end else if (state == ST_REQ && !bus_ack) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign bus_err = bus_err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a byte-arithmetic reference model
module tb_mem_access_unit;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .done      (done),
        .load_data (load_data),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } bus_txn_t;

    typedef struct {
        logic        misalign;
        logic        bus_err;
        logic [31:0] data;
    } result_t;

    bus_txn_t bus_q[$];
    result_t  res_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes_of(input logic [2:0] size);
        if (size[1:0] == 2'b00) return 1;
        if (size[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Issue one request at posedge+1; delay = REQ cycles the responder waits before acking.
    task automatic issue(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int delay);
        int          nb;
        int          off;
        bit          mis;
        bit          tmo;
        bit          drop;
        int          exp_stall;
        int          stalls;
        int          n;
        bit          got;
        logic [31:0] mask;
        logic [31:0] v;
        bus_txn_t    t;
        result_t     r;
        nb   = nbytes_of(size);
        off  = int'(addr % 4);
        mis  = (addr % nb) != 0;
        tmo  = TO_EN && (delay >= TO);
        drop = ($urandom_range(0, 3) == 0);
        r.misalign = mis;
        r.bus_err  = !mis && tmo;
        r.data     = 32'h0;
        if (!mis) begin
            t.addr  = addr - off;
            t.we    = we;
            t.be    = 4'(((1 << nb) - 1) << off);
            for (int i = 0; i < 4; i++) t.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
            t.rdata = rd;
            t.delay = delay;
            bus_q.push_back(t);
            if (!we && !tmo) begin
                mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
                v    = (rd >> (8 * off)) & mask;
                if (!size[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
                r.data = v;
            end
        end
        res_q.push_back(r);
        exp_stall = mis ? 1 : (tmo ? TO + 1 : delay + 2);

        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wd;
        stalls = 0;
        got    = 1'b0;
        n      = 0;
        while (n < 200) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (stall === 1'b1) stalls++;
            if (n == 1 && drop) req_valid = 1'b0;
            n++;
        end
        check("done_seen", 32'(got), 32'h1);
        check("stall_cycles", stalls, exp_stall);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
    endtask

    // Bus responder and bus-side monitor.
    initial begin
        bus_txn_t t;
        int       k;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus_req === 1'b1) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bus_req: got addr %h expected no request", bus_addr);
                    bus_ack = 1'b1;
                    @(posedge clk);
                    #1 bus_ack = 1'b0;
                end else begin
                    t = bus_q.pop_front();
                    check("bus_addr", bus_addr, t.addr);
                    check("bus_we", 32'(bus_we), 32'(t.we));
                    check("bus_be", 32'(bus_be), 32'(t.be));
                    check("bus_wdata", bus_wdata, t.wdata);
                    k = 0;
                    while (k < t.delay && bus_req === 1'b1) begin
                        @(negedge clk);
                        k++;
                    end
                    if (bus_req === 1'b1) begin
                        bus_ack   = 1'b1;
                        bus_rdata = t.rdata;
                        @(posedge clk);
                        #1;
                        bus_ack   = 1'b0;
                        bus_rdata = $urandom;
                    end
                end
            end
        end
    end

    // Result monitor.
    initial begin
        result_t r;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no completion");
                end else begin
                    r = res_q.pop_front();
                    check("misalign", 32'(misalign), 32'(r.misalign));
                    check("bus_err", 32'(bus_err), 32'(r.bus_err));
                    check("load_data", load_data, r.data);
                    check("done_stall", 32'(stall), 32'h0);
                end
            end else begin
                check("quiet_flags", {30'h0, misalign, bus_err}, 32'h0);
                check("quiet_load_data", load_data, 32'h0);
            end
        end
    end

    initial begin
        logic [31:0] a;
        bus_txn_t    t;
        int          n;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_bus_req", 32'(bus_req), 32'h0);
        check("rst_bus_we", 32'(bus_we), 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst       = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;

        issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);
        issue(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0, 0);
        issue(1'b0, 3'b000, 32'h0000_0302, 32'h0, 32'h0080_FF00, 1);
        issue(1'b0, 3'b100, 32'h0000_0302, 32'h0, 32'h0080_FF00, 0);
        issue(1'b0, 3'b001, 32'h0000_0401, 32'h0, 32'h0, 0);
        issue(1'b1, 3'b010, 32'h0000_0500, 32'h1234_5678, 32'h0, 4);
        issue(1'b0, 3'b010, 32'h0000_0504, 32'h0, 32'hCAFE_F00D, 0);
        issue(1'b0, 3'b110, 32'h0000_0508, 32'h0, 32'h8000_0001, 2);
        issue(1'b0, 3'b011, 32'h0000_050C, 32'h0, 32'h8765_4321, 0);
        issue(1'b0, 3'b001, 32'h0000_0512, 32'h0, 32'h8001_7FFF, 0);
        issue(1'b1, 3'b001, 32'h0000_0516, 32'h0000_BEEF, 32'h0, 1);
        issue(1'b0, 3'b010, 32'h0000_0602, 32'h0, 32'h0, 0);
        if (TO_EN) begin
            issue(1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h1111_1111, 100);
            issue(1'b0, 3'b000, 32'h0000_0601, 32'h0, 32'h0000_FF00, TO - 1);
        end

        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            issue(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, $urandom, $urandom_range(0, 6));
        end

        // Reset while the bus access is outstanding.
        t.addr  = 32'h0000_0700;
        t.we    = 1'b1;
        t.be    = 4'hF;
        t.wdata = 32'h1122_3344;
        t.rdata = 32'h0;
        t.delay = 1000;
        bus_q.push_back(t);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 3'b010;
        req_addr  = 32'h0000_0700;
        req_wdata = 32'h1122_3344;
        n = 0;
        while (n < 20 && bus_req !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check("bus_req_before_rst", 32'(bus_req), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_bus_req", 32'(bus_req), 32'h0);
        check("rst_mid_stall", 32'(stall), 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        issue(1'b0, 3'b101, 32'h0000_0802, 32'h0, 32'h9876_5432, 1);

        repeat (4) @(negedge clk);
        check("bus_q_empty", bus_q.size(), 32'h0);
        check("res_q_empty", res_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
